// File: rtl/data_mem_if.sv
// Request/response bundle between a pipeline stage and data_mem_ctrl.
// The err signal exists only when DMC_ALIGN_CHECK_EN is defined.
interface data_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] alu_in;
    logic              req_ready;
    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] alu_out;
`ifdef DMC_ALIGN_CHECK_EN
    logic              err;
`endif

    modport master (
        output req_valid, req_wr, req_addr, req_data, alu_in,
        input  req_ready, stall, resp_valid, resp_data, alu_out
`ifdef DMC_ALIGN_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_data, alu_in,
        output req_ready, stall, resp_valid, resp_data, alu_out
`ifdef DMC_ALIGN_CHECK_EN
        , output err
`endif
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Fixed-latency single-port data memory controller (IDLE/BUSY/DONE FSM).
// Optional misaligned-access detection is enabled by defining DMC_ALIGN_CHECK_EN.
module data_mem_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LAT        = 2
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  ready;
    logic                  accept;
    logic                  access;
    logic                  mis_acc;

    logic                  wr_p0;
    logic [DEPTH_LOG2-1:0] idx_p0;
    logic                  odd_p0;
    logic [DATA_W-1:0]     data_p0;
    logic [DATA_W-1:0]     alu_p0;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  resp_valid_q;
    logic [DATA_W-1:0]     resp_data_q;
    logic [DATA_W-1:0]     alu_out_q;
    logic                  unused_addr;

    // Word index drops the byte bit; upper address bits wrap modulo the depth.
    function automatic logic [DEPTH_LOG2-1:0] mem_index(input logic [ADDR_W-1:0] addr);
        return addr[DEPTH_LOG2:1];
    endfunction

    assign ready         = (state != BUSY);
    assign accept        = bus.req_valid && ready;
    assign bus.req_ready = ready;
    assign bus.stall     = (bus.req_valid && !ready) || (state == BUSY);
    assign unused_addr   = ^bus.req_addr;

`ifdef DMC_ALIGN_CHECK_EN
    assign mis_acc = odd_p0;
`else
    assign mis_acc = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = LAT_M1;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = LAT_M1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request captured at acceptance, held through BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0   <= bus.req_wr;
            idx_p0  <= mem_index(bus.req_addr);
            odd_p0  <= bus.req_addr[0];
            data_p0 <= bus.req_data;
            alu_p0  <= bus.alu_in;
        end
    end

    // The rst term keeps an aborted write from touching the array.
    always_ff @(posedge clk) begin
        if (access && wr_p0 && !mis_acc && !rst) begin
            mem[idx_p0] <= data_p0;
        end
    end

    // Stage p1: response registers, visible during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            alu_out_q    <= '0;
        end else begin
            resp_valid_q <= access;
            if (access) begin
                alu_out_q <= alu_p0;
                if (mis_acc) begin
                    resp_data_q <= '0;
                end else if (!wr_p0) begin
                    resp_data_q <= mem[idx_p0];
                end
            end
        end
    end

`ifdef DMC_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && mis_acc;
        end
    end
    assign bus.err = err_q;
`endif

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.alu_out    = alu_out_q;
endmodule
